// File: rtl/cordic_req_scheduler.sv
// Round-robin front end for a shared fixed-latency CORDIC pipeline.
// Each admitted operand is tagged with its requester id, and the tag is shifted in step with the pipeline.
module cordic_req_scheduler #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned DataW   = 32,
  parameter int unsigned Latency = 16,
  parameter int unsigned IdW     = $clog2(NumReq),
  parameter int unsigned CntW    = $clog2(Latency + 2)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq*DataW-1:0] req_data_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic                    flush_i,
  output logic [DataW-1:0]        cordic_in_o,
  input  logic [DataW-1:0]        cordic_out_i,
  output logic                    rsp_valid_o,
  output logic [IdW-1:0]          rsp_id_o,
  output logic [DataW-1:0]        rsp_data_o,
  output logic                    busy_o,
  output logic [CntW-1:0]         inflight_o
);

  // One extra tag stage covers the cordic_in register in front of the pipeline.
  localparam int unsigned TagDepth = Latency + 1;

  logic [IdW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [DataW-1:0]        cordic_in_q, cordic_in_d;
  logic [TagDepth-1:0]     tag_vld_q, tag_vld_d;
  logic [TagDepth*IdW-1:0] tag_id_q, tag_id_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]          rsp_id_q, rsp_id_d;
  logic [DataW-1:0]        rsp_data_q, rsp_data_d;
  logic [CntW-1:0]         inflight_q, inflight_d;

  logic [NumReq-1:0] grant;
  logic [IdW-1:0]    grant_id;
  logic              found;
  logic              accept;
  logic              rsp_fire;

  function automatic logic [IdW-1:0] wrap_add(logic [IdW-1:0] a, int unsigned k);
    int unsigned s;
    s = 32'(a) + k;
    if (s >= NumReq) s = s - NumReq;
    return IdW'(s);
  endfunction

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!found && req_valid_i[wrap_add(rr_ptr_q, k)]) begin
        found    = 1'b1;
        grant_id = wrap_add(rr_ptr_q, k);
      end
    end
    if (found && !flush_i && rst_ni) grant[grant_id] = 1'b1;
  end

  assign accept   = |grant;
  assign rsp_fire = tag_vld_q[TagDepth-1] & ~flush_i;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cordic_in_d = cordic_in_q;
    if (accept) begin
      rr_ptr_d    = wrap_add(grant_id, 1);
      cordic_in_d = req_data_i[32'(grant_id)*DataW +: DataW];
    end
  end

  always_comb begin
    tag_vld_d = {tag_vld_q[TagDepth-2:0], accept};
    tag_id_d  = {tag_id_q[(TagDepth-1)*IdW-1:0], accept ? grant_id : {IdW{1'b0}}};
    if (flush_i) tag_vld_d = '0;
  end

  always_comb begin
    rsp_valid_d = rsp_fire;
    rsp_id_d    = tag_id_q[TagDepth*IdW-1 -: IdW];
    rsp_data_d  = rsp_fire ? cordic_out_i : rsp_data_q;
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({accept, rsp_fire})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (flush_i) inflight_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      cordic_in_q <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cordic_in_q <= cordic_in_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      inflight_q  <= inflight_d;
    end
  end

  assign req_ready_o = grant;
  assign cordic_in_o = cordic_in_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign inflight_o  = inflight_q;
  assign busy_o      = inflight_q != '0;

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Directed bench for cordic_req_scheduler; a 16-stage bitwise-invert pipeline stands in for CORDIC.
module tb_cordic_req_scheduler;

  localparam int L = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        flush;
  logic [31:0] cordic_in;
  logic [31:0] cordic_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        busy;
  logic [4:0]  inflight;

  int n_cmp = 0;
  int n_err = 0;
  int c;
  int hits;

  logic [31:0] pipe [L];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    pipe[0] <= ~cordic_in;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign cordic_out = pipe[L-1];

  cordic_req_scheduler #(
    .NumReq (4),
    .DataW  (32),
    .Latency(L)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .flush_i     (flush),
    .cordic_in_o (cordic_in),
    .cordic_out_i(cordic_out),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .inflight_o  (inflight)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic wait_rsp(input int maxc, output int cnt);
    cnt = 0;
    while (!rsp_valid && cnt < maxc) begin
      @(negedge clk_i);
      cnt++;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while (inflight != 0 && k < maxc) begin
      @(negedge clk_i);
      k++;
    end
    chk("drain_inflight", 32'(inflight), 32'd0);
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    flush     = 1'b0;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cordic_in", cordic_in, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    req_valid = 4'b0000;
    tick();
    rst_ni = 1'b1;
    tick();

    // Single op from requester 2
    req_valid = 4'b0100;
    req_data[64 +: 32] = 32'h0000_4000;
    #1 chk("t1_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    chk("t1_cordic_in", cordic_in, 32'h0000_4000);
    chk("t1_inflight", 32'(inflight), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_rsp(40, c);
    chk("t1_latency", 32'(c), 32'd17);
    chk("t1_rsp_id", 32'(rsp_id), 32'd2);
    chk("t1_rsp_data", rsp_data, 32'hFFFF_BFFF);
    chk("t1_inflight_after", 32'(inflight), 32'd0);
    chk("t1_busy_after", 32'(busy), 32'd0);
    tick();
    chk("t1_pulse", 32'(rsp_valid), 32'd0);
    chk("t1_hold", rsp_data, 32'hFFFF_BFFF);

    // rr_ptr=3: req 1 alone, then 1 and 3 -> 3 wins
    req_valid = 4'b0010;
    req_data[32 +: 32] = 32'h1111_0001;
    #1 chk("t3_ready_a", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1010;
    req_data[96 +: 32] = 32'h3333_0003;
    #1 chk("t3_ready_b", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0000;
    wait_rsp(40, c);
    chk("t3_latency", 32'(c), 32'd16);
    chk("t3_id_a", 32'(rsp_id), 32'd1);
    chk("t3_data_a", rsp_data, 32'hEEEE_FFFE);
    tick();
    chk("t3_valid_b", 32'(rsp_valid), 32'd1);
    chk("t3_id_b", 32'(rsp_id), 32'd3);
    chk("t3_data_b", rsp_data, 32'hCCCC_FFFC);
    tick();

    // All four valid for 8 cycles
    for (int cyc = 0; cyc < 8; cyc++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h0A00_0000 + 32'(i << 8) + 32'(cyc);
      #1 chk("t2_grant", 32'(req_ready), 32'(1 << (cyc % 4)));
      tick();
    end
    req_valid = 4'b0000;
    chk("t2_peak", 32'(inflight), 32'd8);
    wait_rsp(40, c);
    for (int k = 0; k < 8; k++) begin
      chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t2_rsp_id", 32'(rsp_id), 32'(k % 4));
      chk("t2_rsp_data", rsp_data, ~(32'h0A00_0000 + 32'((k % 4) << 8) + 32'(k)));
      tick();
    end
    chk("t2_end_valid", 32'(rsp_valid), 32'd0);
    chk("t2_end_inflight", 32'(inflight), 32'd0);

    // Steady state from requester 0: accept and response every edge
    for (int cyc = 0; cyc < 26; cyc++) begin
      req_valid = 4'b0001;
      req_data[0 +: 32] = 32'h6000_0000 + 32'(cyc);
      tick();
      if (cyc >= 20) begin
        chk("t6_inflight", 32'(inflight), 32'd17);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t6_rsp_data", rsp_data, ~(32'h6000_0000 + 32'(cyc - 17)));
      end
    end
    req_valid = 4'b0000;
    wait_idle(40);
    tick();

    // Flush three cycles after five accepts
    for (int cyc = 0; cyc < 5; cyc++) begin
      req_valid = 4'b0001;
      req_data[0 +: 32] = 32'h4444_0000 + 32'(cyc);
      tick();
    end
    req_valid = 4'b0000;
    tick();
    tick();
    flush = 1'b1;
    req_valid = 4'b0001;
    #1 chk("t4_flush_ready", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    req_valid = 4'b0000;
    chk("t4_inflight", 32'(inflight), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    hits = 0;
    for (int k = 0; k < 25; k++) begin
      if (rsp_valid) hits++;
      tick();
    end
    chk("t4_no_rsp", 32'(hits), 32'd0);
    req_valid = 4'b0100;
    req_data[64 +: 32] = 32'h2222_0002;
    #1 chk("t4_new_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    wait_rsp(40, c);
    chk("t4_latency", 32'(c), 32'd17);
    chk("t4_rsp_id", 32'(rsp_id), 32'd2);
    chk("t4_rsp_data", rsp_data, 32'hDDDD_FFFD);
    tick();
    tick();
    tick();
    chk("t6_hold_valid", 32'(rsp_valid), 32'd0);
    chk("t6_hold_data", rsp_data, 32'hDDDD_FFFD);

    // Reset with ten ops in flight
    for (int cyc = 0; cyc < 10; cyc++) begin
      req_valid = 4'b0001;
      req_data[0 +: 32] = 32'h5555_0000 + 32'(cyc);
      tick();
    end
    chk("t5_pre_inflight", 32'(inflight), 32'd10);
    #2 rst_ni = 1'b0;
    #1;
    chk("t5_ready", 32'(req_ready), 32'd0);
    chk("t5_inflight", 32'(inflight), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cordic_in", cordic_in, 32'd0);
    chk("t5_rsp_data", rsp_data, 32'd0);
    chk("t5_rsp_id", 32'(rsp_id), 32'd0);
    tick();
    req_valid = 4'b0000;
    rst_ni = 1'b1;
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rsp_valid) hits++;
    end
    chk("t5_no_rsp", 32'(hits), 32'd0);
    chk("t5_idle", 32'(inflight), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
